// File: rtl/logic32_pkg.sv
// rtl/logic32_pkg.sv - shared FSM encoding, LFSR polynomial and fixed vectors for logic32_bist
package logic32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    localparam logic [31:0] VEC0_A = 32'h0000A5A5;
    localparam logic [31:0] VEC0_B = 32'h00005A5A;
    localparam logic [31:0] VEC1_A = 32'h00005A5A;
    localparam logic [31:0] VEC1_B = 32'h00005A5A;

    // Galois step: shift toward the MSB, fold the polynomial back in when the MSB falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

    // An all-zero LFSR never leaves zero, so such a seed is replaced.
    function automatic logic [31:0] nonzero_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/lfsr32.sv
// rtl/lfsr32.sv - 32-bit Galois LFSR with seed reload and step enable
module lfsr32
    import logic32_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        enable,
    output logic [31:0] state
);

    localparam logic [31:0] INIT = nonzero_seed(SEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else if (load) begin
            state <= INIT;
        end else if (enable) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/logic32_bist.sv
// rtl/logic32_bist.sv - BIST controller driving and checking an external 32-bit AND
module logic32_bist
    import logic32_pkg::*;
#(
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hA5A5A5A5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] dut_in1,
    output logic [31:0] dut_in2,
    input  logic [31:0] dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_fail_idx,
    output logic [31:0] first_fail_data
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    state_t      state;
    logic [15:0] idx;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic        start_run;
    logic        more;
    logic        advance;
    logic        lfsr_en;
    logic        mismatch;

    assign start_run = start && (state == ST_IDLE || state == ST_DONE);
    assign more      = idx < LAST_IDX;
    assign advance   = (state == ST_SAMPLE) && more;
    // Vectors 0 and 1 are fixed, so the LFSRs only step when they supply vector 2 onward.
    assign lfsr_en   = advance && (idx != 16'd0);
    assign mismatch  = dut_out != (dut_in1 & dut_in2);

    lfsr32 #(.SEED(SEED)) u_lfsr_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start_run),
        .enable (lfsr_en),
        .state  (lfsr_a)
    );

    lfsr32 #(.SEED(~SEED)) u_lfsr_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start_run),
        .enable (lfsr_en),
        .state  (lfsr_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            idx             <= 16'd0;
            dut_in1         <= 32'h0;
            dut_in2         <= 32'h0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 16'd0;
            first_fail_idx  <= 16'd0;
            first_fail_data <= 32'h0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state           <= ST_DRIVE;
                        idx             <= 16'd0;
                        dut_in1         <= VEC0_A;
                        dut_in2         <= VEC0_B;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= 16'd0;
                        first_fail_idx  <= 16'd0;
                        first_fail_data <= 32'h0;
                    end
                end
                ST_DRIVE: begin
                    state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (err_count == 16'd0) begin
                            first_fail_idx  <= idx;
                            first_fail_data <= dut_out;
                        end
                    end
                    if (advance) begin
                        state <= ST_DRIVE;
                        idx   <= idx + 16'd1;
                        if (idx == 16'd0) begin
                            dut_in1 <= VEC1_A;
                            dut_in2 <= VEC1_B;
                        end else begin
                            dut_in1 <= lfsr_a;
                            dut_in2 <= lfsr_b;
                        end
                    end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 16'd0) && !mismatch;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic32_bist.sv
// tb/tb_logic32_bist.sv - directed self-checking bench for logic32_bist with a modelled external AND
module tb_logic32_bist;

    localparam int          NV   = 8;
    localparam logic [31:0] SEED = 32'hA5A5A5A5;
    localparam logic [31:0] POLY = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dut_in1;
    logic [31:0] dut_in2;
    logic [31:0] dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_fail_idx;
    logic [31:0] first_fail_data;

    int          mode = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] v2a, v2b, v3a, v3b;
    logic [31:0] last_a, last_b;

    always #5 clk = ~clk;

    // External DUT: 0 = good AND, 1 = bit 0 stuck-at-1, 2 = inverted output
    always_comb begin
        dut_out = dut_in1 & dut_in2;
        if (mode == 1) dut_out = (dut_in1 & dut_in2) | 32'h1;
        else if (mode == 2) dut_out = ~(dut_in1 & dut_in2);
    end

    logic32_bist #(.NUM_VECTORS(NV), .SEED(SEED)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dut_in1         (dut_in1),
        .dut_in2         (dut_in2),
        .dut_out         (dut_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_idx  (first_fail_idx),
        .first_fail_data (first_fail_data)
    );

    function automatic logic [31:0] gstep(input logic [31:0] s);
        logic [32:0] t;
        t = {s, 1'b0};
        if (t[32]) return t[31:0] ^ POLY;
        return t[31:0];
    endfunction

    // Vector 2 is the raw seed; vector NV-1 is the seed stepped NV-3 times.
    function automatic logic [31:0] last_vec(input logic [31:0] seed);
        logic [31:0] s;
        s = seed;
        for (int i = 2; i < NV - 1; i++) s = gstep(s);
        return s;
    endfunction

    task automatic wait_done(input int hold, output int cyc);
        cyc = 0;
        if (hold == 0) start = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc >= hold) start = 1'b0;
            if (cyc == 4) begin v2a = dut_in1; v2b = dut_in2; end
            if (cyc == 6) begin v3a = dut_in1; v3b = dut_in2; end
        end
        start = 1'b0;
    endtask

    task automatic run(input int hold, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_done(hold, cyc);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, pass, err_count, first_fail_idx, first_fail_data, dut_in1, dut_in2} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%h idx=%h data=%h in1=%h in2=%h required all 0",
                     busy, done, pass, err_count, first_fail_idx, first_fail_data, dut_in1, dut_in2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_good_and();
        int cyc;
        mode = 0;
        run(0, cyc);
        n_vec++; if (cyc !== 16) begin n_fail++; $display("FAIL good_latency: got %0d required 16", cyc); end
        n_vec++; if (pass !== 1'b1) begin n_fail++; $display("FAIL good_pass: got %b required 1", pass); end
        n_vec++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL good_err: got %h required 0000", err_count); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b required 0", busy); end
        n_vec++; if ({v2a, v2b} !== {32'hA5A5A5A5, 32'h5A5A5A5A}) begin
            n_fail++; $display("FAIL vec2: got %h %h required a5a5a5a5 5a5a5a5a", v2a, v2b); end
        n_vec++; if ({v3a, v3b} !== {32'hCB6B4B49, 32'hB4B4B4B4}) begin
            n_fail++; $display("FAIL vec3: got %h %h required cb6b4b49 b4b4b4b4", v3a, v3b); end
        last_a = last_vec(SEED);
        last_b = last_vec(~SEED);
        n_vec++; if ({dut_in1, dut_in2} !== {last_a, last_b}) begin
            n_fail++; $display("FAIL hold_last_vec: got %h %h required %h %h", dut_in1, dut_in2, last_a, last_b); end
    endtask

    task automatic test_stuck_bit0();
        int cyc;
        mode = 1;
        run(0, cyc);
        n_vec++; if (first_fail_idx !== 16'd0) begin n_fail++; $display("FAIL stuck_idx: got %h required 0000", first_fail_idx); end
        n_vec++; if (first_fail_data !== 32'h1) begin n_fail++; $display("FAIL stuck_data: got %h required 00000001", first_fail_data); end
        n_vec++; if (pass !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL stuck_pass: got pass=%b done=%b required 0 1", pass, done); end
        n_vec++; if (err_count < 16'd3) begin n_fail++; $display("FAIL stuck_err: got %h required at least 0003", err_count); end
    endtask

    task automatic test_inverted();
        int cyc;
        mode = 2;
        run(0, cyc);
        n_vec++; if (err_count !== 16'd8) begin n_fail++; $display("FAIL inv_err: got %h required 0008", err_count); end
        n_vec++; if (first_fail_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL inv_data: got %h required ffffffff", first_fail_data); end
        n_vec++; if (cyc !== 16 || pass !== 1'b0) begin n_fail++; $display("FAIL inv_done: got cyc=%0d pass=%b required 16 0", cyc, pass); end
    endtask

    task automatic test_restart_from_done();
        int cyc;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if ({busy, done, pass, err_count, first_fail_data} !== {1'b1, 1'b0, 1'b0, 16'd0, 32'h0}) begin
            n_fail++; $display("FAIL restart_clear: got busy=%b done=%b pass=%b err=%h data=%h required 1 0 0 0000 00000000",
                               busy, done, pass, err_count, first_fail_data); end
        wait_done(0, cyc);
        n_vec++; if (cyc !== 16 || pass !== 1'b1) begin n_fail++; $display("FAIL restart_run: got cyc=%0d pass=%b required 16 1", cyc, pass); end
    endtask

    task automatic test_start_held();
        int cyc;
        mode = 0;
        run(10, cyc);
        n_vec++; if (cyc !== 16) begin n_fail++; $display("FAIL held_latency: got %0d required 16", cyc); end
        n_vec++; if (pass !== 1'b1 || err_count !== 16'd0) begin n_fail++; $display("FAIL held_result: got pass=%b err=%h required 1 0000", pass, err_count); end
    endtask

    task automatic test_midrun_reset();
        int cyc;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, pass, err_count, first_fail_idx, first_fail_data, dut_in1, dut_in2} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b pass=%b err=%h idx=%h data=%h in1=%h in2=%h required all 0",
                     busy, done, pass, err_count, first_fail_idx, first_fail_data, dut_in1, dut_in2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(0, cyc);
        n_vec++; if (cyc !== 16 || pass !== 1'b1 || err_count !== 16'd0) begin
            n_fail++; $display("FAIL rerun_result: got cyc=%0d pass=%b err=%h required 16 1 0000", cyc, pass, err_count); end
        n_vec++; if ({v2a, v3a, dut_in1, dut_in2} !== {32'hA5A5A5A5, 32'hCB6B4B49, last_a, last_b}) begin
            n_fail++; $display("FAIL rerun_vectors: got %h %h %h %h required a5a5a5a5 cb6b4b49 %h %h",
                               v2a, v3a, dut_in1, dut_in2, last_a, last_b); end
    endtask

    initial begin
        test_reset();
        test_good_and();
        test_stuck_bit0();
        test_inverted();
        test_restart_from_done();
        test_start_held();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
